imm_encoder: RTL and testbench

Pipelined immediate encoder that packs a 32-bit immediate into the 25 upper instruction bits (instr[31:7]) for a given immediate format. It is the inverse of the datapath immediate extractor and is used by the boot/debug loader and self-check logic to build or patch instructions. Every request is range- and alignment-checked so that a bad immediate is flagged instead of being silently truncated. For non-error requests, decoding the output with the same format returns the original immediate.

---
 rtl/imm_encoder_pkg.sv | 20 ++
 rtl/imm_pack_check.sv | 49 ++++
 rtl/imm_encoder.sv | 95 +++++++++
 tb/tb_imm_encoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format codes and helpers for the instruction immediate encoder.
// Format codes here are the ones the datapath extractor decodes.
package imm_encoder_pkg;

   localparam int IMM_CTL_W = 3;

   localparam logic [IMM_CTL_W-1:0] IMM_I_TYPE = 3'd0;
   localparam logic [IMM_CTL_W-1:0] IMM_S_TYPE = 3'd1;
   localparam logic [IMM_CTL_W-1:0] IMM_B_TYPE = 3'd2;
   localparam logic [IMM_CTL_W-1:0] IMM_J_TYPE = 3'd3;
   localparam logic [IMM_CTL_W-1:0] IMM_U_TYPE = 3'd4;

   // True when v[31:msb] are all equal, i.e. v is a sign extension of v[msb:0].
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
      logic [31:0] s;
      s = 32'($signed(v) >>> msb);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_pack_check.sv
// Combinational field packer: scatters an immediate into instr[31:7] and flags
// immediates the chosen format cannot represent.
module imm_pack_check
   import imm_encoder_pkg::*;
(
   input  logic [IMM_CTL_W-1:0] ctl,
   input  logic                 sign_ext,
   input  logic [31:0]          imm,
   input  logic [24:0]          base_bits,
   output logic [24:0]          bits,
   output logic                 err
);

   always_comb begin
      bits = base_bits;
      err  = 1'b0;
      unique case (ctl)
         IMM_I_TYPE: begin
            bits[24:13] = imm[11:0];
            err = sign_ext ? !fits_signed(imm, 11) : (imm[31:12] != '0);
         end
         IMM_S_TYPE: begin
            bits[24:18] = imm[11:5];
            bits[4:0]   = imm[4:0];
            err = !fits_signed(imm, 11);
         end
         IMM_B_TYPE: begin
            bits[24]    = imm[12];
            bits[23:18] = imm[10:5];
            bits[4:1]   = imm[4:1];
            bits[0]     = imm[11];
            err = !fits_signed(imm, 12) || imm[0];
         end
         IMM_J_TYPE: begin
            bits[24]    = imm[20];
            bits[23:14] = imm[10:1];
            bits[13]    = imm[11];
            bits[12:5]  = imm[19:12];
            err = !fits_signed(imm, 20) || imm[0];
         end
         IMM_U_TYPE: begin
            bits[24:5] = imm[31:12];
            err = (imm[11:0] != '0);
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with a saturating error counter.
// S1 holds the packed/checked request, S2 is the output register.
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [IMM_CTL_W-1:0] i_imm_ctl,
   input  logic                 i_sign_ext,
   input  logic [31:0]          i_imm,
   input  logic [24:0]          i_base_bits,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [24:0]          o_instr_bits,
   output logic                 o_err,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   input  logic                 i_err_clr
);

   logic [24:0]          bits_p0;
   logic                 err_p0;
   logic                 vld_p1;
   logic [24:0]          bits_p1;
   logic                 err_p1;
   logic                 vld_p2;
   logic [24:0]          bits_p2;
   logic                 err_p2;
   logic                 s2_load;
   logic                 s1_load;
   logic [ERR_CNT_W-1:0] err_cnt;

   imm_pack_check u_pack (
      .ctl       (i_imm_ctl),
      .sign_ext  (i_sign_ext),
      .imm       (i_imm),
      .base_bits (i_base_bits),
      .bits      (bits_p0),
      .err       (err_p0)
   );

   assign s2_load = !vld_p2 || i_ready;
   assign o_ready = !vld_p1 || s2_load;
   assign s1_load = i_valid && o_ready;

   // Stage 1: request capture
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1 <= 1'b0;
      end else if (o_ready) begin
         vld_p1 <= i_valid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (s1_load) begin
         bits_p1 <= bits_p0;
         err_p1  <= err_p0;
      end
   end

   // Stage 2: output register, held stable while the consumer stalls
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p2  <= 1'b0;
         bits_p2 <= '0;
         err_p2  <= 1'b0;
      end else if (s2_load) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            bits_p2 <= bits_p1;
            err_p2  <= err_p1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_cnt <= '0;
      end else if (i_err_clr) begin
         err_cnt <= '0;
      end else if (vld_p2 && i_ready && err_p2 && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   assign o_valid      = vld_p2;
   assign o_instr_bits = bits_p2;
   assign o_err        = err_p2;
   assign o_err_cnt    = err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, round trips, backpressure,
// error-counter saturation/clear and asynchronous reset.
module tb_imm_encoder;
   import imm_encoder_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_imm_ctl;
   logic        i_sign_ext;
   logic [31:0] i_imm;
   logic [24:0] i_base_bits;
   logic        o_valid;
   logic        i_ready;
   logic [24:0] o_instr_bits;
   logic        o_err;
   logic [7:0]  o_err_cnt;
   logic        i_err_clr;

   imm_encoder #(.ERR_CNT_W(8)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_imm_ctl    (i_imm_ctl),
      .i_sign_ext   (i_sign_ext),
      .i_imm        (i_imm),
      .i_base_bits  (i_base_bits),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_instr_bits (o_instr_bits),
      .o_err        (o_err),
      .o_err_cnt    (o_err_cnt),
      .i_err_clr    (i_err_clr)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        rt;
      logic [2:0]  ctl;
      logic        se;
      logic [31:0] imm;
      logic [24:0] base;
      logic [24:0] bits;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int   checks = 0;
   int   failures = 0;
   int   rx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] ctl, input logic se, input logic [31:0] imm,
                               input logic [24:0] base, input logic [24:0] bits, input logic err);
      exp_t e;
      e.rt = 1'b0; e.ctl = ctl; e.se = se; e.imm = imm; e.base = base; e.bits = bits; e.err = err;
      return e;
   endfunction

   // Datapath extractor model
   function automatic logic [31:0] decode(input logic [2:0] ctl, input logic [24:0] b);
      case (ctl)
         IMM_I_TYPE: return {{20{b[24]}}, b[24:13]};
         IMM_S_TYPE: return {{20{b[24]}}, b[24:18], b[4:0]};
         IMM_B_TYPE: return {{19{b[24]}}, b[24], b[0], b[23:18], b[4:1], 1'b0};
         IMM_J_TYPE: return {{11{b[24]}}, b[24], b[12:5], b[13], b[23:14], 1'b0};
         IMM_U_TYPE: return {b[24:5], 12'b0};
         default:    return 32'h0;
      endcase
   endfunction

   function automatic logic [24:0] imm_mask(input logic [2:0] ctl);
      case (ctl)
         IMM_I_TYPE:             return 25'h1FFE000;
         IMM_S_TYPE, IMM_B_TYPE: return 25'h1FC001F;
         default:                return 25'h1FFFFE0;
      endcase
   endfunction

   task automatic send(input exp_t e);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      i_valid = 1'b1; i_imm_ctl = e.ctl; i_sign_ext = e.se; i_imm = e.imm; i_base_bits = e.base;
      while (!done) begin
         @(negedge i_clk);
         if (o_ready) begin
            sb.push_back(e);
            done = 1;
         end
         @(posedge i_clk); #1;
         n++;
         if (!done && n > 200) begin
            check("send_timeout", 32'd0, 32'd1);
            done = 1;
         end
      end
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || o_valid) && n < 500) begin
         @(posedge i_clk);
         n++;
      end
      #1;
      if (n >= 500) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge i_clk) begin
      if (i_rst_n && o_valid && i_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", {7'd0, o_instr_bits}, 32'hFFFF_FFFF);
         end else begin
            me = sb.pop_front();
            rx++;
            if (me.rt) begin
               check("rt_imm", decode(me.ctl, o_instr_bits), me.imm);
               check("rt_err", {31'd0, o_err}, 32'd0);
               check("rt_base", {7'd0, o_instr_bits & ~imm_mask(me.ctl)},
                     {7'd0, me.base & ~imm_mask(me.ctl)});
            end else begin
               check("bits", {7'd0, o_instr_bits}, {7'd0, me.bits});
               check("err", {31'd0, o_err}, {31'd0, me.err});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [31:0] v;
      int   rx0;

      i_rst_n = 1'b0; i_valid = 1'b0; i_imm_ctl = '0; i_sign_ext = 1'b0; i_imm = '0;
      i_base_bits = '0; i_ready = 1'b1; i_err_clr = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_o_valid", {31'd0, o_valid}, 32'd0);
      check("rst_o_ready", {31'd0, o_ready}, 32'd1);
      check("rst_bits", {7'd0, o_instr_bits}, 32'd0);
      check("rst_err", {31'd0, o_err}, 32'd0);
      check("rst_cnt", {24'd0, o_err_cnt}, 32'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // First result appears two cycles after accept
      send(mk(IMM_I_TYPE, 1'b1, 32'hFFFF_FFFF, 25'h0, 25'h1FFE000, 1'b0));
      @(negedge i_clk);
      check("latency_c1", {31'd0, o_valid}, 32'd0);
      @(posedge i_clk); #1;
      check("latency_c2", {31'd0, o_valid}, 32'd1);
      send(mk(IMM_I_TYPE, 1'b1, 32'h0000_0800, 25'h0, 25'h1000000, 1'b1));
      drain();
      check("cnt_after_one_err", {24'd0, o_err_cnt}, 32'd1);

      send(mk(IMM_I_TYPE, 1'b0, 32'h0000_0800, 25'h0, 25'h1000000, 1'b0));
      send(mk(IMM_B_TYPE, 1'b0, 32'h0000_0FFE, 25'h0, 25'h0FC001F, 1'b0));
      send(mk(IMM_B_TYPE, 1'b0, 32'h0000_0003, 25'h0, 25'h0000002, 1'b1));
      send(mk(IMM_J_TYPE, 1'b0, 32'hFFF0_0000, 25'h0, 25'h1000000, 1'b0));
      send(mk(IMM_U_TYPE, 1'b0, 32'h1234_5000, 25'h000001F, 25'h02468BF, 1'b0));
      send(mk(IMM_U_TYPE, 1'b0, 32'h1234_5001, 25'h000001F, 25'h02468BF, 1'b1));
      send(mk(IMM_S_TYPE, 1'b0, 32'hFFFF_F800, 25'h0, 25'h1000000, 1'b0));
      send(mk(IMM_S_TYPE, 1'b0, 32'h0000_0800, 25'h0, 25'h1000000, 1'b1));
      send(mk(3'd7, 1'b0, 32'h0000_0000, 25'h1234567, 25'h1234567, 1'b1));
      send(mk(IMM_I_TYPE, 1'b1, 32'h0000_0000, 25'h1FFFFFF, 25'h0001FFF, 1'b0));
      drain();
      check("cnt_directed", {24'd0, o_err_cnt}, 32'd5);

      // Round trips through the extractor model
      for (int k = 0; k < 25; k++) begin
         v = $urandom;
         e.rt = 1'b1;
         e.ctl = 3'($urandom_range(0, 4));
         e.se = 1'b1;
         e.base = 25'($urandom);
         e.bits = '0;
         e.err = 1'b0;
         case (e.ctl)
            IMM_I_TYPE, IMM_S_TYPE: e.imm = {{20{v[11]}}, v[11:0]};
            IMM_B_TYPE:             e.imm = {{19{v[12]}}, v[12:1], 1'b0};
            IMM_J_TYPE:             e.imm = {{11{v[20]}}, v[20:1], 1'b0};
            default:                e.imm = {v[31:12], 12'b0};
         endcase
         send(e);
      end
      e.rt = 1'b1; e.ctl = IMM_J_TYPE; e.se = 1'b0; e.imm = 32'hFFF0_0000; e.base = 25'h0000ABC;
      send(e);
      drain();

      // Backpressure: two accepts fill the pipe, then stall
      rx0 = rx;
      i_ready = 1'b0;
      send(mk(IMM_U_TYPE, 1'b0, 32'h0000_1000, 25'h0, 25'h0000020, 1'b0));
      send(mk(IMM_U_TYPE, 1'b0, 32'h0000_2000, 25'h0, 25'h0000040, 1'b0));
      check("bp_ready_low", {31'd0, o_ready}, 32'd0);
      check("bp_valid_held", {31'd0, o_valid}, 32'd1);
      check("bp_bits_held", {7'd0, o_instr_bits}, 32'h0000020);
      fork
         begin
            send(mk(IMM_U_TYPE, 1'b0, 32'h0000_3000, 25'h0, 25'h0000060, 1'b0));
            send(mk(IMM_U_TYPE, 1'b0, 32'h0000_4000, 25'h0, 25'h0000080, 1'b0));
         end
         begin
            repeat (2) @(posedge i_clk);
            #1 i_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 32'(rx - rx0), 32'd4);

      // Error counter saturation
      for (int k = 0; k < 300; k++)
         send(mk(3'd5, 1'b0, 32'(k), 25'(k), 25'(k), 1'b1));
      drain();
      check("cnt_saturated", {24'd0, o_err_cnt}, 32'd255);

      // Clear coincident with an error transfer
      i_ready = 1'b0;
      send(mk(3'd6, 1'b0, 32'h0, 25'h15, 25'h15, 1'b1));
      @(posedge i_clk); #1;
      i_err_clr = 1'b1; i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_err_clr = 1'b0;
      check("cnt_cleared", {24'd0, o_err_cnt}, 32'd0);
      send(mk(3'd6, 1'b0, 32'h0, 25'h16, 25'h16, 1'b1));
      drain();
      check("cnt_after_clear", {24'd0, o_err_cnt}, 32'd1);

      // Asynchronous reset with a full, stalled pipeline
      i_ready = 1'b0;
      send(mk(IMM_U_TYPE, 1'b0, 32'hABCD_E000, 25'h0, 25'h1579BC0, 1'b0));
      send(mk(IMM_U_TYPE, 1'b0, 32'h0000_0001, 25'h0, 25'h0, 1'b1));
      #2 i_rst_n = 1'b0;
      #1;
      check("arst_o_valid", {31'd0, o_valid}, 32'd0);
      check("arst_o_ready", {31'd0, o_ready}, 32'd1);
      check("arst_bits", {7'd0, o_instr_bits}, 32'd0);
      check("arst_err", {31'd0, o_err}, 32'd0);
      check("arst_cnt", {24'd0, o_err_cnt}, 32'd0);
      sb.delete();
      @(posedge i_clk); #3;
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      send(mk(IMM_J_TYPE, 1'b0, 32'h0000_0002, 25'h0, 25'h0004000, 1'b0));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
